sum_accumulator: RTL and testbench

- Downstream consumer of the 8-bit operand adder stage in the lab top level.
- Accepts a stream of 8-bit sums over a valid/ready handshake and accumulates N_SAMPLES of them into a wider register.
- Presents each block total on a held valid/ready output.
- Flags accumulator overflow per block, with optional saturation.

---
 rtl/sum_accumulator.sv | 114 +++++++++++
 tb/tb_sum_accumulator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Block accumulator: sums N_SAMPLES unsigned inputs per block and presents each
// total with an overflow flag on a held valid/ready output.
module sum_accumulator #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int N_SAMPLES = 4,
  parameter int SATURATE  = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ena,
  input  logic                               clear,
  input  logic                               in_valid,
  input  logic [DATA_W-1:0]                  in_data,
  output logic                               in_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ACC_W-1:0]                   out_sum,
  output logic                               out_ovf,
  output logic [$clog2(N_SAMPLES+1)-1:0]     out_count
);

  localparam int CNT_W = $clog2(N_SAMPLES + 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic               out_valid_q, out_valid_d;
  logic               out_ovf_q, out_ovf_d;

  logic [ACC_W:0]     sum_ext;
  logic               ovf_flag;
  logic [ACC_W-1:0]   sum_res;
  logic               accept;
  logic               last_sample;

  assign in_ready  = ena && (state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign out_count = (state_q == ACCUM) ? count_q : '0;

  always_comb begin
    // One extra bit catches the carry; the overflow flag is sticky within a block.
    sum_ext     = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
    ovf_flag    = sum_ext[ACC_W] | ovf_q;
    sum_res     = ((SATURATE != 0) && ovf_flag) ? '1 : sum_ext[ACC_W-1:0];
    last_sample = (count_q == CNT_W'(N_SAMPLES - 1));

    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
    out_ovf_d   = out_ovf_q;

    if (ena) begin
      if (clear) begin
        state_d     = ACCUM;
        acc_d       = '0;
        count_d     = '0;
        ovf_d       = 1'b0;
        out_valid_d = 1'b0;
        out_ovf_d   = 1'b0;
      end else if (state_q == HOLD) begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end else if (accept) begin
        if (last_sample) begin
          out_sum_d   = sum_res;
          out_ovf_d   = ovf_flag;
          out_valid_d = 1'b1;
          state_d     = HOLD;
          acc_d       = '0;
          count_d     = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d   = sum_res;
          count_d = count_q + 1'b1;
          ovf_d   = ovf_flag;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: three parameterisations share one stimulus stream and
// are checked every cycle against a block-level arithmetic model.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena, clear, in_valid, out_ready;
  logic [7:0] in_data;

  logic        rdy0, val0, ovf0;
  logic [15:0] sum0;
  logic [2:0]  cnt0;
  logic        rdy1, val1, ovf1;
  logic [7:0]  sum1;
  logic [1:0]  cnt1;
  logic        rdy2, val2, ovf2;
  logic [7:0]  sum2;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  sum_accumulator u_dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_ready(rdy0), .out_valid(val0), .out_ready(out_ready),
    .out_sum(sum0), .out_ovf(ovf0), .out_count(cnt0));

  sum_accumulator #(.DATA_W(8), .ACC_W(8), .N_SAMPLES(2), .SATURATE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_ready(rdy1), .out_valid(val1), .out_ready(out_ready),
    .out_sum(sum1), .out_ovf(ovf1), .out_count(cnt1));

  sum_accumulator #(.DATA_W(8), .ACC_W(8), .N_SAMPLES(2), .SATURATE(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_ready(rdy2), .out_valid(val2), .out_ready(out_ready),
    .out_sum(sum2), .out_ovf(ovf2), .out_count(cnt2));

  // DUT outputs gathered into arrays for a common compare loop
  logic [15:0] o_sum [3];
  logic        o_val [3];
  logic        o_ovf [3];
  logic        o_rdy [3];
  logic [2:0]  o_cnt [3];
  assign o_sum[0] = sum0;          assign o_sum[1] = {8'h00, sum1}; assign o_sum[2] = {8'h00, sum2};
  assign o_val[0] = val0;          assign o_val[1] = val1;          assign o_val[2] = val2;
  assign o_ovf[0] = ovf0;          assign o_ovf[1] = ovf1;          assign o_ovf[2] = ovf2;
  assign o_rdy[0] = rdy0;          assign o_rdy[1] = rdy1;          assign o_rdy[2] = rdy2;
  assign o_cnt[0] = cnt0;          assign o_cnt[1] = {1'b0, cnt1};  assign o_cnt[2] = {1'b0, cnt2};

  localparam int NS  [3] = '{4, 2, 2};
  localparam int AW  [3] = '{16, 8, 8};
  localparam int SAT [3] = '{0, 0, 1};

  // Model: exact running sum of the partial block, compared against 2^ACC_W at block end
  longint m_psum [3] = '{0, 0, 0};
  int     m_n    [3] = '{0, 0, 0};
  bit     m_hold [3] = '{0, 0, 0};
  longint m_rsum [3] = '{0, 0, 0};
  bit     m_rovf [3] = '{0, 0, 0};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_psum[i] = 0; m_n[i] = 0; m_hold[i] = 0; m_rsum[i] = 0; m_rovf[i] = 0;
      end else if (ena) begin
        if (clear) begin
          m_psum[i] = 0; m_n[i] = 0; m_hold[i] = 0; m_rovf[i] = 0;
        end else if (m_hold[i]) begin
          if (out_ready) m_hold[i] = 0;
        end else if (in_valid) begin
          m_psum[i] += longint'(in_data);
          m_n[i]++;
          if (m_n[i] == NS[i]) begin
            longint lim;
            lim       = longint'(1) << AW[i];
            m_rovf[i] = (m_psum[i] >= lim);
            m_rsum[i] = (m_rovf[i] && SAT[i] != 0) ? lim - 1 : m_psum[i] % lim;
            m_hold[i] = 1;
            m_psum[i] = 0;
            m_n[i]    = 0;
            if (i == 0) $display("txn block sum=%0d ovf=%0d t=%0t", m_rsum[i], m_rovf[i], $time);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("in_ready[%0d]", i),  o_rdy[i], (ena && !m_hold[i]) ? 1 : 0);
      chk($sformatf("out_valid[%0d]", i), o_val[i], m_hold[i]);
      chk($sformatf("out_sum[%0d]", i),   o_sum[i], m_rsum[i]);
      chk($sformatf("out_count[%0d]", i), o_cnt[i], m_hold[i] ? 0 : m_n[i]);
      if (m_hold[i]) chk($sformatf("out_ovf[%0d]", i), o_ovf[i], m_rovf[i]);
    end
  end

  // Inputs change 1 time unit after a rising edge and are held through the next one
  task automatic drive(input bit e, input bit c, input bit v, input logic [7:0] d, input bit r);
    ena = e; clear = c; in_valid = v; in_data = d; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] d, input bit r);
    drive(1, 0, 1, d, r);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sum", sum0, 0);
    chk("reset_valid", val0, 0);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 1);

    // Test 1: 10,20,30,40
    drive(1, 1, 0, 0, 1);
    chk("t1_cnt_a", cnt0, 0);
    feed(10, 1); chk("t1_cnt_b", cnt0, 1);
    feed(20, 1); chk("t1_cnt_c", cnt0, 2);
    feed(30, 1); chk("t1_cnt_d", cnt0, 3);
    feed(40, 1);
    chk("t1_valid", val0, 1); chk("t1_sum", sum0, 100); chk("t1_ovf", ovf0, 0); chk("t1_cnt_e", cnt0, 0);

    // Test 2: 8-bit overflow, wrap and saturate variants
    drive(1, 1, 0, 0, 0);
    feed(200, 0); feed(100, 0);
    chk("t2_wrap_sum", sum1, 44);  chk("t2_wrap_ovf", ovf1, 1);
    chk("t2_sat_sum", sum2, 255);  chk("t2_sat_ovf", ovf2, 1);

    // Test 3: backpressure
    drive(1, 1, 0, 0, 0);
    feed(1, 0); feed(2, 0); feed(3, 0); feed(4, 0);
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", val0, 1); chk("t3_hold_sum", sum0, 10); chk("t3_hold_rdy", rdy0, 0);
      drive(1, 0, 0, 0, 0);
    end
    drive(1, 0, 0, 0, 1);
    chk("t3_release_valid", val0, 0); chk("t3_release_rdy", rdy0, 1);

    // Test 4: bubbles and an ena=0 cycle with in_valid high
    drive(1, 1, 0, 0, 1);
    feed(5, 1); drive(1, 0, 0, 0, 1); feed(5, 1);
    drive(0, 0, 1, 5, 1);
    chk("t4_frozen_cnt", cnt0, 2); chk("t4_frozen_rdy", rdy0, 0);
    feed(5, 1); drive(1, 0, 0, 0, 1);
    chk("t4_not_yet", val0, 0);
    feed(5, 1);
    chk("t4_valid", val0, 1); chk("t4_sum", sum0, 20);

    // Test 5: clear mid-block, then clear in HOLD
    drive(1, 1, 0, 0, 0);
    feed(7, 0); feed(9, 0);
    drive(1, 1, 0, 0, 0);
    feed(1, 0); feed(1, 0); feed(1, 0); feed(1, 0);
    chk("t5_sum", sum0, 4); chk("t5_ovf", ovf0, 0); chk("t5_valid", val0, 1);
    drive(1, 1, 0, 0, 0);
    chk("t5_clr_valid", val0, 0); chk("t5_clr_sum_kept", sum0, 4);

    // Test 6: asynchronous reset between edges
    feed(3, 1); feed(4, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_sum", sum0, 0); chk("t6_async_cnt", cnt0, 0); chk("t6_async_valid", val0, 0);
    rst_n = 1'b1;
    feed(1, 1); feed(2, 1); feed(3, 1); feed(4, 1);
    chk("t6_sum", sum0, 10); chk("t6_valid", val0, 1);

    // Randomised traffic, including occasional reset pulses between edges
    for (int k = 0; k < 3000; k++) begin
      ena       = ($urandom_range(0, 9) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 99) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    drive(1, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
